// File: rtl/parallel_send.sv
// Transmit-side pattern generator: INIT marker, fixed gap, then a READY-paced burst of incrementing words.
// Optional single-word error injection is enabled by defining PARALLEL_SEND_ERRINJ_EN.
module parallel_send #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned GAP   = 4
) (
  input  logic        RSTX,
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic        READY,
`ifdef PARALLEL_SEND_ERRINJ_EN
  input  logic        ERR_INJ,
`endif
  output logic        INIT,
  output logic        DOPUSH,
  output logic [31:0] DOUT,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] SENT_CNT
);

  typedef enum logic [1:0] {IDLE, S_INIT, S_GAP, S_SEND} state_t;

  localparam logic [15:0] WORDS_W = 16'(WORDS);
  localparam logic [7:0]  GAP_M1  = 8'(GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] data_cnt_q, data_cnt_d;
  logic        init_q, init_d;
  logic        dopush_q, dopush_d;
  logic [31:0] dout_q, dout_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [15:0] sent_cnt_q, sent_cnt_d;
  logic        push;
  logic        inj_bit;

`ifdef PARALLEL_SEND_ERRINJ_EN
  logic err_armed_q, err_armed_d;

  // The armed flag is consumed by the push it corrupts; pulses while armed add nothing.
  always_comb begin
    err_armed_d = err_armed_q | ERR_INJ;
    if (push) err_armed_d = 1'b0;
    if (CLR)  err_armed_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) err_armed_q <= 1'b0;
    else       err_armed_q <= err_armed_d;
  end

  assign inj_bit = err_armed_q;
`else
  assign inj_bit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    data_cnt_d  = data_cnt_q;
    init_d      = 1'b0;
    dopush_d    = 1'b0;
    dout_d      = dout_q;
    last_d      = 1'b0;
    done_d      = last_q;
    sent_cnt_d  = sent_cnt_q;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d     = S_INIT;
          remaining_d = WORDS_W;
          sent_cnt_d  = '0;
        end
      end
      S_INIT: begin
        init_d  = 1'b1;
        gap_d   = GAP_M1;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_SEND;
        else               gap_d   = gap_q - 8'd1;
      end
      S_SEND: begin
        if (READY) begin
          push        = 1'b1;
          dopush_d    = 1'b1;
          dout_d      = data_cnt_q ^ {31'd0, inj_bit};
          data_cnt_d  = data_cnt_q + 32'd1;
          remaining_d = remaining_q - 16'd1;
          sent_cnt_d  = (sent_cnt_q == 16'hFFFF) ? sent_cnt_q : sent_cnt_q + 16'd1;
          // DONE follows one cycle after the final word is on the bus.
          if (remaining_q <= 16'd1) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (CLR) begin
      state_d     = IDLE;
      remaining_d = '0;
      gap_d       = '0;
      data_cnt_d  = '0;
      init_d      = 1'b0;
      dopush_d    = 1'b0;
      dout_d      = '0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      sent_cnt_d  = '0;
      push        = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      data_cnt_q  <= '0;
      init_q      <= 1'b0;
      dopush_q    <= 1'b0;
      dout_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      sent_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      data_cnt_q  <= data_cnt_d;
      init_q      <= init_d;
      dopush_q    <= dopush_d;
      dout_q      <= dout_d;
      last_q      <= last_d;
      done_q      <= done_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

  assign INIT     = init_q;
  assign DOPUSH   = dopush_q;
  assign DOUT     = dout_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign SENT_CNT = sent_cnt_q;

endmodule
